// File: rtl/ifetch_mem_responder.sv
// rtl/ifetch_mem_responder.sv - memory-side fetch responder: one 64-bit bus read per fetch, 32-bit word out
//
// Purpose:
//    Accepts a PC from the IFU and issues a single read on a valid/ready
//    memory bus. It returns the selected 32-bit instruction half of the
//    64-bit beat. Redirect flushes discard in-flight data. Bus errors,
//    misaligned PCs and response timeouts are turned into FAULT_INST with
//    fault_o set.
//
// Ports:
//    clk, rst_n       clock, synchronous active-low reset
//    fetch_req_i      IFU fetch request
//    fetch_addr_i     PC, latched when a request is accepted
//    flush_i          redirect: kill the current fetch
//    stall_i          downstream stall: hold the delivered instruction
//    inst_o           instruction word (0 when inst_valid_o is low)
//    inst_valid_o     inst_o valid; consumed when inst_valid_o && !stall_i
//    fault_o          inst_o is FAULT_INST due to a fault
//    mem_arvalid_o    read address valid
//    mem_arready_i    read address accepted
//    mem_araddr_o     8-byte aligned read address
//    mem_rvalid_i     read data valid
//    mem_rready_o     ready for read data
//    mem_rdata_i      64-bit read data
//    mem_rresp_i      response code, nonzero = error

module ifetch_mem_responder #(
   parameter int          ADDR_W      = 64,
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [31:0] FAULT_INST  = 32'h00100073
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   input  logic              flush_i,
   input  logic              stall_i,
   output logic [31:0]       inst_o,
   output logic              inst_valid_o,
   output logic              fault_o,
   output logic              mem_arvalid_o,
   input  logic              mem_arready_i,
   output logic [ADDR_W-1:0] mem_araddr_o,
   input  logic              mem_rvalid_i,
   output logic              mem_rready_o,
   input  logic [63:0]       mem_rdata_i,
   input  logic [1:0]        mem_rresp_i
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_DROP,
      S_OUT
   } state_t;

   // Timeout fires on the edge where the counter would reach TIMEOUT_CYC,
   // i.e. after TIMEOUT_CYC R-cycles without rvalid.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   // Bits [1:0] of the PC only matter for the misalignment check at
   // accept time, so they are not stored.
   logic [ADDR_W-1:2]   r_addr;
   logic [ADDR_W-1:2]   w_addr_nxt;
   logic [7:0]          r_cnt;
   logic [7:0]          w_cnt_nxt;
   logic                r_kill;
   logic                w_kill_nxt;
   logic [31:0]         r_inst;
   logic [31:0]         w_inst_nxt;
   logic                r_fault;
   logic                w_fault_nxt;

   logic                w_misalign;
   logic [31:0]         w_word;

   assign w_misalign = (fetch_addr_i[1:0] != 2'b00);
   assign w_word     = r_addr[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_kill  <= 1'b0;
         r_inst  <= '0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_kill  <= w_kill_nxt;
         r_inst  <= w_inst_nxt;
         r_fault <= w_fault_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_cnt_nxt   = r_cnt;
      w_kill_nxt  = r_kill;
      w_inst_nxt  = r_inst;
      w_fault_nxt = r_fault;

      case (r_state)
         S_IDLE: begin
            if (fetch_req_i && !flush_i) begin
               w_addr_nxt = fetch_addr_i[ADDR_W-1:2];
               w_kill_nxt = 1'b0;
               if (w_misalign) begin
                  w_state_nxt = S_OUT;
                  w_inst_nxt  = FAULT_INST;
                  w_fault_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_AR;
               end
            end
         end

         S_AR: begin
            // arvalid cannot be withdrawn once raised, so a flush here is
            // remembered and the response is drained in DROP instead.
            if (flush_i) begin
               w_kill_nxt = 1'b1;
            end
            if (mem_arready_i) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (r_kill || flush_i) ? S_DROP : S_R;
            end
         end

         S_R: begin
            if (mem_rvalid_i) begin
               if (flush_i) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_OUT;
                  if (mem_rresp_i != 2'b00) begin
                     w_inst_nxt  = FAULT_INST;
                     w_fault_nxt = 1'b1;
                  end else begin
                     w_inst_nxt  = w_word;
                     w_fault_nxt = 1'b0;
                  end
               end
            end else if (flush_i) begin
               w_state_nxt = S_DROP;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_state_nxt = S_OUT;
               w_inst_nxt  = FAULT_INST;
               w_fault_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end

         S_DROP: begin
            if (mem_rvalid_i) begin
               w_state_nxt = S_IDLE;
            end
         end

         S_OUT: begin
            // Flush beats stall: the held instruction is thrown away.
            if (flush_i) begin
               w_state_nxt = S_IDLE;
            end else if (!stall_i) begin
               if (fetch_req_i) begin
                  w_addr_nxt = fetch_addr_i[ADDR_W-1:2];
                  w_kill_nxt = 1'b0;
                  if (w_misalign) begin
                     w_state_nxt = S_OUT;
                     w_inst_nxt  = FAULT_INST;
                     w_fault_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_AR;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign mem_arvalid_o = (r_state == S_AR);
   assign mem_araddr_o  = {r_addr[ADDR_W-1:3], 3'b000};
   assign mem_rready_o  = (r_state == S_R) || (r_state == S_DROP);
   assign inst_valid_o  = (r_state == S_OUT);
   assign inst_o        = inst_valid_o ? r_inst : 32'd0;
   assign fault_o       = inst_valid_o & r_fault;

endmodule

// File: tb/tb_ifetch_mem_responder.sv
// tb/tb_ifetch_mem_responder.sv - table-driven self-checking bench for ifetch_mem_responder

module tb_ifetch_mem_responder;

   localparam logic [31:0] FI = 32'h00100073;

   logic        clk;
   logic        rst_n;
   logic        fetch_req_i;
   logic [63:0] fetch_addr_i;
   logic        flush_i;
   logic        stall_i;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        fault_o;
   logic        mem_arvalid_o;
   logic        mem_arready_i;
   logic [63:0] mem_araddr_o;
   logic        mem_rvalid_i;
   logic        mem_rready_o;
   logic [63:0] mem_rdata_i;
   logic [1:0]  mem_rresp_i;

   int checks = 0;
   int errors = 0;

   ifetch_mem_responder #(
      .ADDR_W      (64),
      .TIMEOUT_CYC (255),
      .FAULT_INST  (FI)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fetch_req_i   (fetch_req_i),
      .fetch_addr_i  (fetch_addr_i),
      .flush_i       (flush_i),
      .stall_i       (stall_i),
      .inst_o        (inst_o),
      .inst_valid_o  (inst_valid_o),
      .fault_o       (fault_o),
      .mem_arvalid_o (mem_arvalid_o),
      .mem_arready_i (mem_arready_i),
      .mem_araddr_o  (mem_araddr_o),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rready_o  (mem_rready_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_rresp_i   (mem_rresp_i)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Inputs applied for one clock edge, and the outputs expected right after it.
   typedef struct {
      logic        req;
      logic [63:0] addr;
      logic        flush;
      logic        stall;
      logic        arrdy;
      logic        rvld;
      logic [63:0] rdata;
      logic [1:0]  rresp;
      logic        e_arv;
      logic [63:0] e_araddr;
      logic        e_rrdy;
      logic        e_ival;
      logic [31:0] e_inst;
      logic        e_flt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic req, input logic [63:0] addr, input logic flush, input logic stall,
      input logic arrdy, input logic rvld, input logic [63:0] rdata, input logic [1:0] rresp,
      input logic e_arv, input logic [63:0] e_araddr, input logic e_rrdy,
      input logic e_ival, input logic [31:0] e_inst, input logic e_flt);
      vec_t v;
      v.req = req;     v.addr = addr;   v.flush = flush; v.stall = stall;
      v.arrdy = arrdy; v.rvld = rvld;   v.rdata = rdata; v.rresp = rresp;
      v.e_arv = e_arv; v.e_araddr = e_araddr; v.e_rrdy = e_rrdy;
      v.e_ival = e_ival; v.e_inst = e_inst; v.e_flt = e_flt;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      fetch_req_i   = v.req;
      fetch_addr_i  = v.addr;
      flush_i       = v.flush;
      stall_i       = v.stall;
      mem_arready_i = v.arrdy;
      mem_rvalid_i  = v.rvld;
      mem_rdata_i   = v.rdata;
      mem_rresp_i   = v.rresp;
   endtask

   task automatic drive_idle();
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic check_outs(input string tag, input int idx, input vec_t v);
      chk({tag, ".arvalid"}, idx, 64'(mem_arvalid_o), 64'(v.e_arv));
      if (v.e_arv) chk({tag, ".araddr"}, idx, mem_araddr_o, v.e_araddr);
      chk({tag, ".rready"}, idx, 64'(mem_rready_o), 64'(v.e_rrdy));
      chk({tag, ".inst_valid"}, idx, 64'(inst_valid_o), 64'(v.e_ival));
      chk({tag, ".inst"}, idx, 64'(inst_o), 64'(v.e_inst));
      chk({tag, ".fault"}, idx, 64'(fault_o), 64'(v.e_flt));
   endtask

   vec_t zero_v;

   initial begin
      int n;
      zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ---------------- reset state ----------------
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      check_outs("reset", 0, zero_v);
      rst_n = 1'b1;

      // ---------------- vector table ----------------
      // Aligned fetch of upper word, zero wait states.
      vecs.push_back(mk(1, 64'h80000004, 0, 0, 0, 0, 0, 0,                      1, 64'h80000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h00000013_00100093, 0,             0, 0, 0, 1, 32'h00000013, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      // Lower word, stalled for four cycles in OUT.
      vecs.push_back(mk(1, 64'h80000000, 0, 0, 0, 0, 0, 0,                      1, 64'h80000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h00000013_00100093, 0,             0, 0, 0, 1, 32'h00100093, 0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,                              0, 0, 0, 1, 32'h00100093, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      // Flush in R, rvalid two cycles later, then a normal fetch at 0x80000100.
      vecs.push_back(mk(1, 64'h80000000, 0, 0, 0, 0, 0, 0,                      1, 64'h80000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h11111111_22222222, 0,             0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 64'h80000100, 0, 0, 0, 0, 0, 0,                      1, 64'h80000100, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'hDEADBEEF_12345678, 0,             0, 0, 0, 1, 32'h12345678, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      // Flush together with rvalid.
      vecs.push_back(mk(1, 64'h80000008, 0, 0, 0, 0, 0, 0,                      1, 64'h80000008, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 1, 64'hAAAAAAAA_BBBBBBBB, 0,             0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      // Flush in AR, arready three cycles later: arvalid held, then DROP.
      vecs.push_back(mk(1, 64'h80000010, 0, 0, 0, 0, 0, 0,                      1, 64'h80000010, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0,                                 1, 64'h80000010, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 1, 64'h80000010, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 1, 64'h80000010, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h55555555_66666666, 0,             0, 0, 0, 0, 0, 0));
      // Bus error response.
      vecs.push_back(mk(1, 64'h80000004, 0, 0, 0, 0, 0, 0,                      1, 64'h80000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h00000013_00100093, 2'b10,         0, 0, 0, 1, FI, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      // Misaligned PC: fault without a bus access.
      vecs.push_back(mk(1, 64'h80000002, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 1, FI, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      // Back-to-back: next request taken straight from OUT, last one misaligned.
      vecs.push_back(mk(1, 64'h80000000, 0, 0, 0, 0, 0, 0,                      1, 64'h80000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h11111111_22222222, 0,             0, 0, 0, 1, 32'h22222222, 0));
      vecs.push_back(mk(1, 64'h80000004, 0, 0, 0, 0, 0, 0,                      1, 64'h80000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h33333333_44444444, 0,             0, 0, 0, 1, 32'h33333333, 0));
      vecs.push_back(mk(1, 64'h80000006, 0, 0, 0, 0, 0, 0,                      0, 0, 0, 1, FI, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      // Flush while stalled in OUT drops the instruction.
      vecs.push_back(mk(1, 64'h80000000, 0, 0, 0, 0, 0, 0,                      1, 64'h80000000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'h77777777_88888888, 0,             0, 0, 0, 1, 32'h88888888, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check_outs("vec", i, vecs[i]);
      end

      // ---------------- timeout: no rvalid for 255 cycles ----------------
      drive(mk(1, 64'h80000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("timeout.in_r", 0, 64'(mem_rready_o), 64'd1);
      drive_idle();
      n = 0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (inst_valid_o) begin
            n = c;
            break;
         end
      end
      chk("timeout.cycles", 0, 64'(n), 64'd255);
      chk("timeout.inst", 0, 64'(inst_o), 64'(FI));
      chk("timeout.fault", 0, 64'(fault_o), 64'd1);
      @(negedge clk);
      check_outs("timeout.idle", 0, zero_v);

      // ---------------- reset asserted mid-R ----------------
      drive(mk(1, 64'h80000004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      drive(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      chk("rst_mid.in_r", 0, 64'(mem_rready_o), 64'd1);
      drive(mk(0, 0, 0, 0, 0, 1, 64'h99999999_AAAAAAAA, 0, 0, 0, 0, 0, 0, 0));
      rst_n = 1'b0;
      @(negedge clk);
      check_outs("rst_mid", 0, zero_v);
      rst_n = 1'b1;
      drive_idle();
      @(negedge clk);
      check_outs("rst_mid.after", 1, zero_v);
      // IDLE after reset: a fresh fetch goes through AR normally.
      vecs.delete();
      vecs.push_back(mk(1, 64'h80000204, 0, 0, 0, 0, 0, 0,                      1, 64'h80000200, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,                                 0, 0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 64'hCAFEF00D_0BADC0DE, 0,             0, 0, 0, 1, 32'hCAFEF00D, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                                 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check_outs("post_rst", i, vecs[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
